// File: rtl/clock_period_meter.sv
// clock_period_meter
// Measures a slow, asynchronous square wave against the 100 MHz board clock.
// It reports three values:
//   - the period between the last two rising edges,
//   - the high time within that period,
//   - the clock_divider setting that would reproduce the same frequency.
//
// Ports
//   clock_100MHz    in   board clock, all logic on its rising edge
//   reset           in   synchronous, active-high
//   clock_in        in   asynchronous signal under measurement
//   period_count    out  board cycles between the last two rising edges
//   high_count      out  board cycles clock_in was high within that period
//   div_count_value out  (period_count >> 1) - 1, or 0 for periods below 2
//   measure_valid   out  one-cycle pulse when the three results update
//   no_signal       out  high while no rising edge has been seen for
//                        TIMEOUT_COUNT cycles
module clock_period_meter #(
   parameter logic [31:0] TIMEOUT_COUNT = 32'd100_000_000
) (
   input  logic        clock_100MHz,
   input  logic        reset,
   input  logic        clock_in,
   output logic [31:0] period_count,
   output logic [31:0] high_count,
   output logic [31:0] div_count_value,
   output logic        measure_valid,
   output logic        no_signal
);

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURING  = 2'd1,
      TIMEOUT    = 2'd2
   } state_t;

   state_t      state_r;
   logic        sync1_r;
   logic        sync2_r;
   logic        prev_r;
   logic [31:0] cycle_cnt_r;
   logic [31:0] high_acc_r;
   logic        rise_s;
   logic        timeout_hit_s;
   logic [31:0] new_period_s;

   // Divider setting that regenerates a given period; odd periods round down.
   function automatic logic [31:0] div_from_period(input logic [31:0] period);
      logic [31:0] div;
      if (period < 32'd2) begin
         div = 32'd0;
      end else begin
         div = (period >> 1) - 32'd1;
      end
      return div;
   endfunction

   // Edge detect and the timeout condition; a rise always beats the timeout.
   always_comb begin
      rise_s        = sync2_r & ~prev_r;
      timeout_hit_s = (cycle_cnt_r == (TIMEOUT_COUNT - 32'd1)) && !rise_s;
      new_period_s  = cycle_cnt_r + 32'd1;
   end

   // Two-flop synchronizer plus history flop.
   // The flops reset high so that an input held high through reset is not
   // seen as a rising edge.
   always_ff @(posedge clock_100MHz) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= clock_in;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Period counter and high-time accumulator, both restarted by each rise.
   // high_acc_r loads 1 on a rise because the rising sample itself was high.
   always_ff @(posedge clock_100MHz) begin
      if (reset) begin
         cycle_cnt_r <= 32'd0;
         high_acc_r  <= 32'd0;
      end else if (rise_s) begin
         cycle_cnt_r <= 32'd0;
         high_acc_r  <= 32'd1;
      end else begin
         if (state_r != TIMEOUT) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
         end else begin
            cycle_cnt_r <= cycle_cnt_r;
         end
         high_acc_r <= high_acc_r + {31'd0, sync2_r};
      end
   end

   // Measurement state machine with registered result outputs.
   // The first rise after reset or timeout only opens a period.
   always_ff @(posedge clock_100MHz) begin
      if (reset) begin
         state_r         <= WAIT_FIRST;
         period_count    <= 32'd0;
         high_count      <= 32'd0;
         div_count_value <= 32'd0;
         measure_valid   <= 1'b0;
         no_signal       <= 1'b0;
      end else begin
         measure_valid <= 1'b0;
         case (state_r)
            WAIT_FIRST: begin
               if (rise_s) begin
                  state_r <= MEASURING;
               end else if (timeout_hit_s) begin
                  state_r         <= TIMEOUT;
                  no_signal       <= 1'b1;
                  period_count    <= 32'd0;
                  high_count      <= 32'd0;
                  div_count_value <= 32'd0;
               end else begin
                  state_r <= WAIT_FIRST;
               end
            end
            MEASURING: begin
               if (rise_s) begin
                  period_count    <= new_period_s;
                  high_count      <= high_acc_r;
                  div_count_value <= div_from_period(new_period_s);
                  measure_valid   <= 1'b1;
                  state_r         <= MEASURING;
               end else if (timeout_hit_s) begin
                  state_r         <= TIMEOUT;
                  no_signal       <= 1'b1;
                  period_count    <= 32'd0;
                  high_count      <= 32'd0;
                  div_count_value <= 32'd0;
               end else begin
                  state_r <= MEASURING;
               end
            end
            TIMEOUT: begin
               if (rise_s) begin
                  state_r   <= MEASURING;
                  no_signal <= 1'b0;
               end else begin
                  state_r <= TIMEOUT;
               end
            end
            default: begin
               state_r         <= WAIT_FIRST;
               no_signal       <= 1'b0;
               period_count    <= 32'd0;
               high_count      <= 32'd0;
               div_count_value <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures an incoming slow clock (typically a `clock_divider` output or an external square wave) against the 100 MHz board clock. It reports the period, the high time, and the equivalent `div_count_value`: the value that, fed back into `clock_divider`, reproduces the same frequency. It is the inverse of the divider, used for self-check and for displaying rates on the calculator.

## Interface
- `TIMEOUT_COUNT`, default 100_000_000: board-clock cycles without a rising edge before `no_signal` asserts (1 s). Range 2 .. 2^32-1.
- `clock_100MHz`  in  1: board clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `clock_in`  in  1: asynchronous signal under measurement.
- `period_count`  out  32: board cycles between the last two rising edges of `clock_in`.
- `high_count`  out  32: board cycles `clock_in` was high within that period.
- `div_count_value`  out  32: `(period_count >> 1) - 1`, or 0 when `period_count < 2`.
- `measure_valid`  out  1: one-cycle pulse when the three result outputs update.
- `no_signal`  out  1: level; high while the timeout is active.

## Operation
- Synchronizer: `clock_in` → `sync1` → `sync2` → `prev`. All three flops reset to 1. `rise = sync2 & ~prev`. Because of the reset value, an input held high through reset produces no rise.
- 32-bit `cycle_cnt`:
  - cleared to 0 on `rise`;
  - otherwise increments in WAIT_FIRST and MEASURING;
  - holds in TIMEOUT.
- 32-bit `high_acc`:
  - loaded to 1 on `rise`;
  - otherwise adds `sync2` each cycle.
- On `rise` in MEASURING, latch results:
  - `period_count <= cycle_cnt + 1`
  - `high_count <= high_acc`
  - `div_count_value` from the new period (floor for odd periods)
  - pulse `measure_valid`
- State machine:
  - WAIT_FIRST (reset state): on `rise` go to MEASURING with no result update. If `cycle_cnt == TIMEOUT_COUNT-1` and no `rise`, go to TIMEOUT.
  - MEASURING: on `rise` latch results and stay. If `cycle_cnt == TIMEOUT_COUNT-1` and no `rise`, go to TIMEOUT.
  - TIMEOUT: `no_signal = 1`; `period_count`, `high_count` and `div_count_value` are forced to 0. On `rise`, go to MEASURING, clear `no_signal`, and do not pulse `measure_valid`. The first edge only starts a period.
- Simultaneous `rise` and timeout condition: `rise` wins; no timeout.
- Counter cannot overflow because the timeout caps it below 2^32.

## Timing
- Reset values:
  - all outputs 0;
  - state WAIT_FIRST;
  - `cycle_cnt` 0, `high_acc` 0;
  - sync flops 1.
- Edge latency: a `clock_in` rise sampled at edge t gives `rise` high in cycle t+2; results and `measure_valid` are visible in cycle t+3.
- For a clean input of period P cycles, `measure_valid` pulses every P cycles. Minimum measurable P is 2.
- Timeout: after `rise` detected in cycle r with no further rise, `no_signal` is visible from cycle r+TIMEOUT_COUNT+1. From reset release the count starts at the first cycle after `reset` deasserts.
- Reset mid-period: any partial measurement is discarded. The next `measure_valid` requires two rises after release.
- `measure_valid` is never high for two consecutive cycles.

## Test plan
- Drive `clock_in` from a `clock_divider` with `div_count_value = 4` (period 10, 5 high). Required: after the second rise, `measure_valid` pulses every 10 cycles with `period_count = 10`, `high_count = 5`, `div_count_value = 4`.
- Latency and edge cases:
  - Single rise at edge t following an earlier rise → `measure_valid` exactly at t+3.
  - Pattern 3 high / 7 low → `period = 10`, `high = 3`.
  - Pattern 6 high / 5 low → `period = 11`, `div = 4`.
  - Pattern 1 high / 1 low → `period = 2`, `high = 1`, `div = 0`.
- Timeout with `TIMEOUT_COUNT = 50`:
  - Stop the input after a rise detected at cycle r → `no_signal = 1` and all result outputs 0 from r+51.
  - Restart the input → `no_signal` clears at the first detected rise with no `measure_valid`; valid results come on the second rise.
- Rise coinciding with `cycle_cnt == TIMEOUT_COUNT-1` → no `no_signal`, and `measure_valid` pulses with `period_count = TIMEOUT_COUNT`.
- Hold `clock_in` high through and after reset → no rise and no `measure_valid`. The first real rise after a low phase is a start edge only.
- Assert `reset` for 1 cycle mid-period during steady 10-cycle input → all outputs 0 the next cycle; the next `measure_valid` comes only after two subsequent rises, with `period_count = 10`.
